mem_access: RTL and testbench

Memory-access and PC-update stage of the no-pipeline core, sitting directly downstream of the execution stage. It consumes the ALU result, the propagated second register operand and the resolved branch decision and target. It performs loads and stores on a single-outstanding request/acknowledge data-memory port, including byte-lane steering, sign/zero extension and alignment checking. It returns write-back data and the next PC to the core with a valid pulse.

---
 rtl/mem_access_if.sv | 32 +++
 rtl/mem_access.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_access.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory port of the mem_access stage: single-outstanding request/acknowledge bus.
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  // The stage drives the request side.
  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_ack,
    input  dmem_rdata
  );

  // The memory answers with ack and read data.
  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory-access and PC-update stage of the no-pipeline core.
// Accepts one execution result at a time, performs at most one data-memory
// access with lane steering and load extension, then pulses out_valid with
// write-back data, next PC and an error flag.
module mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  alu_res,
  input  logic [31:0]  store_data,
  input  logic [2:0]   funct3,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic         is_branch_in,
  input  logic [31:0]  branch_target,
  input  logic [31:0]  pc_value,
  mem_access_if.master dmem,
  output logic         out_valid,
  output logic [31:0]  wb_data,
  output logic [31:0]  next_pc,
  output logic         mem_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // At least 8 bits, wider only if the timeout needs it.
  localparam int CNT_W = (ACK_TIMEOUT > 255) ? $clog2(ACK_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] TO_LIMIT =
    (ACK_TIMEOUT == 0) ? {CNT_W{1'b0}} : CNT_W'(ACK_TIMEOUT - 1);

  // Byte enables for an access of the given size at the given byte offset.
  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      3'b000, 3'b100: be = 4'b0001 << lo;
      3'b001, 3'b101: be = 4'b0011 << lo;
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  // Store data replicated into every lane so the byte enables pick the right one.
  function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{sd[7:0]}};
      2'b01:   wd = {2{sd[15:0]}};
      default: wd = sd;
    endcase
    return wd;
  endfunction

  // Select the addressed byte/half from the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rd);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rd >> {lo, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = rd;
      3'b100:  res = {24'h00_0000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // Any reason a memory op must not reach the bus.
  function automatic logic access_err(input logic rd, input logic wr, input logic [2:0] f3,
                                      input logic [1:0] lo);
    logic bad_f3;
    logic misal;
    case (f3)
      3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
      3'b100, 3'b101:         bad_f3 = wr;
      default:                bad_f3 = 1'b1;
    endcase
    misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3 == 3'b010) && (lo != 2'b00));
    return (rd && wr) || bad_f3 || misal;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [31:0]      dmem_wdata_q, dmem_wdata_d;
  logic [3:0]       dmem_be_q, dmem_be_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [31:0]      next_pc_q, next_pc_d;
  logic             mem_err_q, mem_err_d;
  // Access context kept until the response is formatted.
  logic [1:0]       lo_q, lo_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      npc_pend_q, npc_pend_d;

  logic [31:0]      npc;
  logic             is_mem;

  // Next-state, bus request and response formatting.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    dmem_be_d    = dmem_be_q;
    out_valid_d  = 1'b0;
    wb_data_d    = wb_data_q;
    next_pc_d    = next_pc_q;
    mem_err_d    = mem_err_q;
    lo_d         = lo_q;
    f3_d         = f3_q;
    npc_pend_d   = npc_pend_q;
    npc          = is_branch_in ? branch_target : (pc_value + 32'd4);
    is_mem       = mem_read || mem_write;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            wb_data_d   = alu_res;
            next_pc_d   = npc;
            mem_err_d   = 1'b0;
          end else if (access_err(mem_read, mem_write, funct3, alu_res[1:0])) begin
            state_d     = S_DONE;
            out_valid_d = 1'b1;
            wb_data_d   = 32'h0000_0000;
            next_pc_d   = npc;
            mem_err_d   = 1'b1;
          end else begin
            state_d      = S_ACCESS;
            cnt_d        = {CNT_W{1'b0}};
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {alu_res[31:2], 2'b00};
            dmem_be_d    = lane_be(funct3, alu_res[1:0]);
            dmem_wdata_d = lane_wdata(funct3, store_data);
            lo_d         = alu_res[1:0];
            f3_d         = funct3;
            npc_pend_d   = npc;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ACCESS: begin
        if (dmem.dmem_ack) begin
          state_d     = S_DONE;
          dmem_req_d  = 1'b0;
          out_valid_d = 1'b1;
          wb_data_d   = dmem_we_q ? 32'h0000_0000 : load_extract(f3_q, lo_q, dmem.dmem_rdata);
          next_pc_d   = npc_pend_q;
          mem_err_d   = 1'b0;
        end else if ((ACK_TIMEOUT != 0) && (cnt_q == TO_LIMIT)) begin
          state_d     = S_DONE;
          dmem_req_d  = 1'b0;
          out_valid_d = 1'b1;
          wb_data_d   = 32'h0000_0000;
          next_pc_d   = npc_pend_q;
          mem_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d    = S_IDLE;
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops the request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0000_0000;
      dmem_wdata_q <= 32'h0000_0000;
      dmem_be_q    <= 4'b0000;
      out_valid_q  <= 1'b0;
      wb_data_q    <= 32'h0000_0000;
      next_pc_q    <= 32'h0000_0000;
      mem_err_q    <= 1'b0;
      lo_q         <= 2'b00;
      f3_q         <= 3'b000;
      npc_pend_q   <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      dmem_be_q    <= dmem_be_d;
      out_valid_q  <= out_valid_d;
      wb_data_q    <= wb_data_d;
      next_pc_q    <= next_pc_d;
      mem_err_q    <= mem_err_d;
      lo_q         <= lo_d;
      f3_q         <= f3_d;
      npc_pend_q   <= npc_pend_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign dmem.dmem_be    = dmem_be_q;
  assign out_valid       = out_valid_q;
  assign wb_data         = wb_data_q;
  assign next_pc         = next_pc_q;
  assign mem_err         = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected responses, a
// monitor pops and compares on every out_valid pulse.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_res;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        mem_read;
  logic        mem_write;
  logic        is_branch_in;
  logic [31:0] branch_target;
  logic [31:0] pc_value;
  logic        out_valid;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic        mem_err;

  mem_access_if dmem ();

  mem_access #(.ACK_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .alu_res       (alu_res),
    .store_data    (store_data),
    .funct3        (funct3),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .is_branch_in  (is_branch_in),
    .branch_target (branch_target),
    .pc_value      (pc_value),
    .dmem          (dmem),
    .out_valid     (out_valid),
    .wb_data       (wb_data),
    .next_pc       (next_pc),
    .mem_err       (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] wb;
    logic [31:0] npc;
    logic        err;
    logic        chk_wb;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] alu, sd, pc, tgt, rdata, wdata, wb, npc;
    logic        br, rd, wr, bus, chk_wb, err;
    logic [2:0]  f3;
    logic [3:0]  be;
    int          wait_c, reqc;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[18];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] alu, input logic [31:0] sd,
                              input logic [31:0] pc, input logic br, input logic [31:0] tgt,
                              input logic [2:0] f3, input logic rd, input logic wr,
                              input logic bus, input int wait_c, input logic [31:0] rdata,
                              input logic [3:0] be, input logic [31:0] wdata, input int reqc,
                              input logic chk_wb, input logic [31:0] wb,
                              input logic [31:0] npc, input logic err);
    vec_t v;
    v.name = name; v.alu = alu; v.sd = sd; v.pc = pc; v.br = br; v.tgt = tgt;
    v.f3 = f3; v.rd = rd; v.wr = wr; v.bus = bus; v.wait_c = wait_c; v.rdata = rdata;
    v.be = be; v.wdata = wdata; v.reqc = reqc; v.chk_wb = chk_wb; v.wb = wb;
    v.npc = npc; v.err = err;
    return v;
  endfunction

  // Monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_out_valid: got out_valid=1 want no pulse (wb=%h npc=%h)",
                 wb_data, next_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.chk_wb) chk({mon_e.name, " wb_data"}, wb_data, mon_e.wb);
        chk({mon_e.name, " next_pc"}, next_pc, mon_e.npc);
        chk({mon_e.name, " mem_err"}, {31'd0, mem_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit poke);
    int   guard;
    int   cyc;
    int   reqc;
    bit   done;
    exp_t e;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({v.name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    alu_res = v.alu; store_data = v.sd; pc_value = v.pc; is_branch_in = v.br;
    branch_target = v.tgt; funct3 = v.f3; mem_read = v.rd; mem_write = v.wr;
    in_valid = 1'b1;
    e.name = v.name; e.wb = v.wb; e.npc = v.npc; e.err = v.err; e.chk_wb = v.chk_wb;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({v.name, " dmem_req"}, {31'd0, dmem.dmem_req}, {31'd0, v.bus});
    if (v.bus) begin
      chk({v.name, " dmem_addr"}, dmem.dmem_addr, {v.alu[31:2], 2'b00});
      chk({v.name, " dmem_be"}, {28'd0, dmem.dmem_be}, {28'd0, v.be});
      chk({v.name, " dmem_we"}, {31'd0, dmem.dmem_we}, {31'd0, v.wr});
      chk({v.name, " dmem_wdata"}, dmem.dmem_wdata, v.wdata);
      cyc = 0; reqc = 0; done = 1'b0;
      while (!done && cyc < 20) begin
        if (dmem.dmem_req) begin
          reqc++;
          if (poke && cyc == 0) begin
            in_valid = 1'b1; alu_res = 32'hBAD0_0000; mem_read = 1'b0; mem_write = 1'b0;
          end
          if (cyc == v.wait_c) begin
            dmem.dmem_ack = 1'b1;
            dmem.dmem_rdata = v.rdata;
          end
          @(posedge clk);
          #1;
          dmem.dmem_ack = 1'b0;
          in_valid = 1'b0;
          @(negedge clk);
          cyc++;
        end else begin
          done = 1'b1;
        end
      end
      chk({v.name, " req_cycles"}, 32'(reqc), 32'(v.reqc));
      chk({v.name, " out_valid_after_req"}, {31'd0, out_valid}, 32'd1);
    end else begin
      chk({v.name, " out_valid_next_cycle"}, {31'd0, out_valid}, 32'd1);
    end
    guard = 0;
    #1;
    while (exp_q.size() != 0 && guard < 5) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk({v.name, " response_seen"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Hard stop in case anything above fails to make progress.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_res = 32'd0; store_data = 32'd0; funct3 = 3'd0;
    mem_read = 1'b0; mem_write = 1'b0; is_branch_in = 1'b0; branch_target = 32'd0;
    pc_value = 32'd0; dmem.dmem_ack = 1'b0; dmem.dmem_rdata = 32'd0;

    //       name         alu           sd            pc            br    tgt           f3      rd    wr    bus  wait rdata         be       wdata         reqc chkwb wb            npc           err
    vecs[0]  = mk("alu",     32'h0000_1234, 32'h0,        32'h0000_0100, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0000_1234, 32'h0000_0104, 1'b0);
    vecs[1]  = mk("lb",      32'h0000_1003, 32'h0,        32'h0000_0200, 1'b0, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 2, 32'h80FF_FF00, 4'b1000, 32'h0,        3, 1'b1, 32'hFFFF_FF80, 32'h0000_0204, 1'b0);
    vecs[2]  = mk("lbu",     32'h0000_1003, 32'h0,        32'h0000_0204, 1'b0, 32'h0,        3'b100, 1'b1, 1'b0, 1'b1, 2, 32'h80FF_FF00, 4'b1000, 32'h0,        3, 1'b1, 32'h0000_0080, 32'h0000_0208, 1'b0);
    vecs[3]  = mk("sh",      32'h0000_2002, 32'hDEAD_BEEF, 32'h0000_0300, 1'b0, 32'h0,       3'b001, 1'b0, 1'b1, 1'b1, 0, 32'h0,        4'b1100, 32'hBEEF_BEEF, 1, 1'b0, 32'h0,        32'h0000_0304, 1'b0);
    vecs[4]  = mk("lw_mis",  32'h0000_3001, 32'h0,        32'h0000_0400, 1'b0, 32'h0,        3'b010, 1'b1, 1'b0, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0,        32'h0000_0404, 1'b1);
    vecs[5]  = mk("sh_mis",  32'h0000_3003, 32'hDEAD_BEEF, 32'h0000_0500, 1'b1, 32'h0000_0040, 3'b001, 1'b0, 1'b1, 1'b0, 0, 32'h0,   4'b0000, 32'h0,        0, 1'b1, 32'h0,        32'h0000_0040, 1'b1);
    vecs[6]  = mk("timeout", 32'h0000_5000, 32'h0,        32'h0000_0600, 1'b0, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, -1, 32'h0,       4'b1111, 32'h0,        4, 1'b1, 32'h0,        32'h0000_0604, 1'b1);
    vecs[7]  = mk("ack_last",32'h0000_5004, 32'h0,        32'h0000_0604, 1'b0, 32'h0,        3'b010, 1'b1, 1'b0, 1'b1, 3, 32'hCAFE_F00D, 4'b1111, 32'h0,        4, 1'b1, 32'hCAFE_F00D, 32'h0000_0608, 1'b0);
    vecs[8]  = mk("lh",      32'h0000_6002, 32'h0,        32'h0000_0700, 1'b0, 32'h0,        3'b001, 1'b1, 1'b0, 1'b1, 1, 32'h8001_1234, 4'b1100, 32'h0,        2, 1'b1, 32'hFFFF_8001, 32'h0000_0704, 1'b0);
    vecs[9]  = mk("lhu",     32'h0000_6000, 32'h0,        32'h0000_0708, 1'b0, 32'h0,        3'b101, 1'b1, 1'b0, 1'b1, 0, 32'h8001_F234, 4'b0011, 32'h0,        1, 1'b1, 32'h0000_F234, 32'h0000_070C, 1'b0);
    vecs[10] = mk("sb",      32'h0000_7001, 32'h1234_56A5, 32'h0000_0800, 1'b0, 32'h0,       3'b000, 1'b0, 1'b1, 1'b1, 1, 32'h0,        4'b0010, 32'hA5A5_A5A5, 2, 1'b0, 32'h0,        32'h0000_0804, 1'b0);
    vecs[11] = mk("sw_br",   32'h0000_7004, 32'h1122_3344, 32'h0000_0900, 1'b1, 32'h0000_1000, 3'b010, 1'b0, 1'b1, 1'b1, 0, 32'h0,  4'b1111, 32'h1122_3344, 1, 1'b0, 32'h0,        32'h0000_1000, 1'b0);
    vecs[12] = mk("ld_f3",   32'h0000_8000, 32'h0,        32'h0000_0A00, 1'b0, 32'h0,        3'b011, 1'b1, 1'b0, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0,        32'h0000_0A04, 1'b1);
    vecs[13] = mk("st_f3",   32'h0000_8000, 32'h55,       32'h0000_0A04, 1'b0, 32'h0,        3'b100, 1'b0, 1'b1, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0,        32'h0000_0A08, 1'b1);
    vecs[14] = mk("rw",      32'h0000_8000, 32'h0,        32'h0000_0A08, 1'b0, 32'h0,        3'b010, 1'b1, 1'b1, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'h0,        32'h0000_0A0C, 1'b1);
    vecs[15] = mk("pc_wrap", 32'hDEAD_0001, 32'h0,        32'hFFFF_FFFC, 1'b0, 32'h0,        3'b000, 1'b0, 1'b0, 1'b0, 0, 32'h0,        4'b0000, 32'h0,        0, 1'b1, 32'hDEAD_0001, 32'h0000_0000, 1'b0);
    vecs[16] = mk("poke_lb", 32'h0000_9000, 32'h0,        32'h0000_0B00, 1'b0, 32'h0,        3'b000, 1'b1, 1'b0, 1'b1, 2, 32'h0000_007F, 4'b0001, 32'h0,        3, 1'b1, 32'h0000_007F, 32'h0000_0B04, 1'b0);
    vecs[17] = mk("after_rst",32'h0000_55AA, 32'h0,       32'h0000_0C00, 1'b1, 32'h0000_0C80, 3'b000, 1'b0, 1'b0, 1'b0, 0, 32'h0,  4'b0000, 32'h0,        0, 1'b1, 32'h0000_55AA, 32'h0000_0C80, 1'b0);

    // Reset state.
    #1;
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst dmem_req", {31'd0, dmem.dmem_req}, 32'd0);
    chk("rst dmem_we", {31'd0, dmem.dmem_we}, 32'd0);
    chk("rst dmem_addr", dmem.dmem_addr, 32'd0);
    chk("rst dmem_wdata", dmem.dmem_wdata, 32'd0);
    chk("rst dmem_be", {28'd0, dmem.dmem_be}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst wb_data", wb_data, 32'd0);
    chk("rst next_pc", next_pc, 32'd0);
    chk("rst mem_err", {31'd0, mem_err}, 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Stray ack while idle must be ignored.
    @(negedge clk);
    dmem.dmem_ack = 1'b1;
    @(posedge clk);
    #1 dmem.dmem_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_ack in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      run_vec(vecs[i], i == 16);
    end

    // Reset in the middle of an access.
    @(negedge clk);
    alu_res = 32'h0000_4000; funct3 = 3'b010; mem_read = 1'b1; mem_write = 1'b0;
    is_branch_in = 1'b0; pc_value = 32'h0000_0D00;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst req_before", {31'd0, dmem.dmem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst req_async_drop", {31'd0, dmem.dmem_req}, 32'd0);
    chk("mid_rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst out_valid", {31'd0, out_valid}, 32'd0);
    run_vec(vecs[17], 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
